// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the instruction memory
// address, and registers the fetched word into the IF/ID pipeline register.
// A one-cycle BOOT state after reset emits a bubble before fetching starts.
module if_fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_data,
  output logic [7:0]  imem_addr,
  output logic [31:0] pc_current,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;

  // Sequential successor of the current PC; wraps naturally modulo 2^32.
  assign pc_plus4 = pc_q + 32'd4;

  // Next-state and datapath selection: redirect beats stall, stall holds.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_count_d   = fetch_count_q;

    unique case (state_q)
      BOOT: begin
        // Control inputs are ignored here; PC stays at 0 and IF/ID is a bubble.
        state_d         = RUN;
        pc_d            = 32'd0;
        ifid_instr_d    = 32'd0;
        ifid_pc_plus4_d = 32'd0;
        ifid_valid_d    = 1'b0;
      end
      RUN: begin
        if (branch_taken) begin
          // Redirect: force word alignment and flush the wrong-path fetch.
          pc_d            = {branch_target[31:2], 2'b00};
          ifid_instr_d    = 32'd0;
          ifid_pc_plus4_d = 32'd0;
          ifid_valid_d    = 1'b0;
        end else if (!stall) begin
          pc_d            = pc_plus4;
          ifid_instr_d    = imem_data;
          ifid_pc_plus4_d = pc_plus4;
          ifid_valid_d    = 1'b1;
          fetch_count_d   = fetch_count_q + 16'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State and pipeline registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= BOOT;
      pc_q            <= 32'd0;
      ifid_instr_q    <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      fetch_count_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q         <= state_d;
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_count_q   <= fetch_count_d;
    end
  end

  assign imem_addr     = pc_q[7:0];
  assign pc_current    = pc_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a 256-byte combinational
// instruction memory model.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_data;
  logic [7:0]  imem_addr;
  logic [31:0] pc_current;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .pc_current    (pc_current),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid),
    .fetch_count   (fetch_count)
  );

  assign imem_data = mem[imem_addr[7:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset low for two cycles and release it at a falling edge.
  task automatic apply_reset();
    reset         = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    repeat (2) @(negedge clk);
    checks++; if (pc_current !== 32'd0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc_current, 32'd0); end
    checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, 8'd0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'd0) begin errors++; $display("FAIL rst_instr got=%h exp=0", ifid_instr); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%h exp=0", fetch_count); end
    reset = 1'b1;
    // BOOT edge with redirect and stall asserted: both must be ignored.
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    checks++; if (pc_current !== 32'd0) begin errors++; $display("FAIL boot_pc got=%h exp=%h", pc_current, 32'd0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got=%b exp=0", ifid_valid); end
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [4];
    exp_instr[0] = 32'hE2110000; exp_instr[1] = 32'hE0805183;
    exp_instr[2] = 32'hE7D12000; exp_instr[3] = 32'hE58A5000;
    apply_reset();
    step();
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc_plus4 !== 32'd0) begin errors++; $display("FAIL seq_bubble got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_instr, ifid_pc_plus4); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (ifid_instr !== exp_instr[i]) begin errors++; $display("FAIL seq_instr%0d got=%h exp=%h", i, ifid_instr, exp_instr[i]); end
      checks++; if (ifid_pc_plus4 !== 32'(4 * (i + 1)) || ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_pc4_%0d got=%h/%b exp=%h/1", i, ifid_pc_plus4, ifid_valid, 4 * (i + 1)); end
    end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got=%h exp=4", fetch_count); end
    checks++; if (pc_current !== 32'h10) begin errors++; $display("FAIL seq_pc got=%h exp=10", pc_current); end
  endtask

  task automatic test_stall();
    apply_reset();
    repeat (3) step();
    checks++; if (pc_current !== 32'd8) begin errors++; $display("FAIL stall_pre_pc got=%h exp=8", pc_current); end
    stall = 1'b1;
    repeat (2) step();
    checks++; if (pc_current !== 32'd8) begin errors++; $display("FAIL stall_pc got=%h exp=8", pc_current); end
    checks++; if (ifid_instr !== 32'hE0805183 || ifid_pc_plus4 !== 32'd8 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid got=%h/%h/%b exp=e0805183/8/1", ifid_instr, ifid_pc_plus4, ifid_valid); end
    checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL stall_count got=%h exp=2", fetch_count); end
    stall = 1'b0;
    step();
    checks++; if (ifid_instr !== 32'hE7D12000 || ifid_pc_plus4 !== 32'd12) begin errors++; $display("FAIL stall_release got=%h/%h exp=e7d12000/c", ifid_instr, ifid_pc_plus4); end
    checks++; if (fetch_count !== 16'd3) begin errors++; $display("FAIL stall_release_count got=%h exp=3", fetch_count); end
  endtask

  task automatic test_branch();
    apply_reset();
    repeat (5) step();
    branch_taken = 1'b1; branch_target = 32'h0000000E;
    step();
    branch_taken = 1'b0;
    checks++; if (pc_current !== 32'h0C) begin errors++; $display("FAIL br_pc got=%h exp=c", pc_current); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0 || ifid_pc_plus4 !== 32'd0) begin errors++; $display("FAIL br_bubble got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_instr, ifid_pc_plus4); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL br_count got=%h exp=4", fetch_count); end
    step();
    checks++; if (ifid_instr !== 32'hE58A5000 || ifid_pc_plus4 !== 32'h10 || ifid_valid !== 1'b1) begin errors++; $display("FAIL br_target got=%h/%h/%b exp=e58a5000/10/1", ifid_instr, ifid_pc_plus4, ifid_valid); end
    checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL br_target_count got=%h exp=5", fetch_count); end
  endtask

  task automatic test_branch_stall();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h20;
    step();
    stall = 1'b0; branch_taken = 1'b0;
    checks++; if (pc_current !== 32'h20) begin errors++; $display("FAIL brst_pc got=%h exp=20", pc_current); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'd0) begin errors++; $display("FAIL brst_bubble got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
    checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL brst_count got=%h exp=5", fetch_count); end
  endtask

  task automatic test_wrap();
    apply_reset();
    step();
    repeat (63) step();
    checks++; if (pc_current !== 32'hFC || imem_addr !== 8'hFC) begin errors++; $display("FAIL wrap_pre got=%h/%h exp=fc/fc", pc_current, imem_addr); end
    step();
    checks++; if (pc_current !== 32'h100) begin errors++; $display("FAIL wrap_pc got=%h exp=100", pc_current); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got=%h exp=0", imem_addr); end
    checks++; if (ifid_instr !== mem[63] || ifid_pc_plus4 !== 32'h100) begin errors++; $display("FAIL wrap_ifid got=%h/%h exp=%h/100", ifid_instr, ifid_pc_plus4, mem[63]); end
    repeat (65535 - 64) step();
    checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL count_max got=%h exp=ffff", fetch_count); end
    step();
    checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL count_wrap got=%h exp=0", fetch_count); end
    checks++; if (pc_current !== 32'h00040000) begin errors++; $display("FAIL count_wrap_pc got=%h exp=40000", pc_current); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (6) step();
    checks++; if (pc_current !== 32'h14 || fetch_count !== 16'd5) begin errors++; $display("FAIL ar_pre got=%h/%h exp=14/5", pc_current, fetch_count); end
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    #1 reset = 1'b0;
    #1;
    checks++; if (pc_current !== 32'd0 || imem_addr !== 8'd0) begin errors++; $display("FAIL ar_pc got=%h/%h exp=0/0", pc_current, imem_addr); end
    checks++; if (ifid_instr !== 32'd0 || ifid_pc_plus4 !== 32'd0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL ar_ifid got=%h/%h/%b exp=0/0/0", ifid_instr, ifid_pc_plus4, ifid_valid); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL ar_count got=%h exp=0", fetch_count); end
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (ifid_valid !== 1'b0 || pc_current !== 32'd0) begin errors++; $display("FAIL ar_boot got=%b/%h exp=0/0", ifid_valid, pc_current); end
    step();
    checks++; if (ifid_instr !== 32'hE2110000 || ifid_pc_plus4 !== 32'd4) begin errors++; $display("FAIL ar_first got=%h/%h exp=e2110000/4", ifid_instr, ifid_pc_plus4); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'hE2110000; mem[1] = 32'hE0805183;
    mem[2] = 32'hE7D12000; mem[3] = 32'hE58A5000;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
